am2940_dma_ctrl: RTL and testbench

Sequencer that programs and steps an am2940 DMA address generator on behalf of a requesting master. On a start pulse it writes the am2940 control register, loads the word count and base address, enables the counters, then presents one address per transfer to a peripheral over a valid/ready handshake. After each accepted transfer it pulses the am2940 count inputs, and it stops when the am2940 raises done. It sits between the system DMA request logic and the am2940 instance.

---
 rtl/am2940_dma_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_am2940_dma_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/am2940_dma_ctrl.sv
// Sequencer that programs an am2940 DMA address generator and steps it once per
// accepted peripheral transfer until the am2940 reports done.
module am2940_dma_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] base_addr,
    input  logic [7:0] word_cnt,
    input  logic [7:0] ctrl_word,
    output logic [2:0] am_instr,
    output logic [7:0] am_data,
    output logic       am_oeaddr,
    output logic       am_aci,
    output logic       am_wci,
    input  logic [7:0] am_address,
    input  logic       am_done,
    output logic       xfer_valid,
    output logic [7:0] xfer_addr,
    input  logic       xfer_ready,
    output logic       busy,
    output logic       fin,
    output logic       err,
    output logic [8:0] xfer_cnt
);

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 9;

    localparam logic [IW-1:0] I_WR_CR = 3'b000;
    localparam logic [IW-1:0] I_LD_AD = 3'b101;
    localparam logic [IW-1:0] I_LD_WC = 3'b110;
    localparam logic [IW-1:0] I_EN    = 3'b111;
    localparam logic [IW-1:0] I_RD    = 3'b011;

    localparam logic [CW-1:0] CNT_LIMIT = CW'(256);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CR,
        S_LD_WC,
        S_LD_AD,
        S_EN,
        S_XFER,
        S_STEP,
        S_CHECK,
        S_FIN
    } state_t;

    state_t state, next_state;

    logic [DW-1:0] base_q;
    logic [DW-1:0] wc_q;
    logic          handshake;

    logic [IW-1:0] instr_d;
    logic [DW-1:0] data_d;
    logic          step_d;
    logic          valid_d;
    logic          busy_d;
    logic          fin_d;
    logic          err_d;
    logic [CW-1:0] cnt_d;

    assign handshake = (state == S_XFER) && xfer_valid && xfer_ready;

    // Address passes straight through only while a transfer is offered.
    assign xfer_addr = xfer_valid ? am_address : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // registered yet line up with the state they belong to.
    always_comb begin
        next_state = state;
        err_d      = err;
        cnt_d      = xfer_cnt;
        instr_d    = I_RD;
        data_d     = '0;
        step_d     = 1'b0;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        fin_d      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_WR_CR;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                end
            end
            S_WR_CR: begin
                if (abort) begin
                    next_state = S_FIN;
                    err_d      = 1'b1;
                end else begin
                    next_state = S_LD_WC;
                end
            end
            S_LD_WC: begin
                if (abort) begin
                    next_state = S_FIN;
                    err_d      = 1'b1;
                end else begin
                    next_state = S_LD_AD;
                end
            end
            S_LD_AD: begin
                if (abort) begin
                    next_state = S_FIN;
                    err_d      = 1'b1;
                end else begin
                    next_state = S_EN;
                end
            end
            S_EN: begin
                if (abort) begin
                    next_state = S_FIN;
                    err_d      = 1'b1;
                end else begin
                    next_state = S_XFER;
                end
            end
            S_XFER: begin
                // A handshake takes priority over abort in the same cycle.
                if (handshake) begin
                    next_state = S_STEP;
                    cnt_d      = xfer_cnt + CW'(1);
                end else if (abort) begin
                    next_state = S_FIN;
                    err_d      = 1'b1;
                end
            end
            S_STEP: begin
                next_state = S_CHECK;
            end
            S_CHECK: begin
                if (abort || (!am_done && (xfer_cnt == CNT_LIMIT))) begin
                    next_state = S_FIN;
                    err_d      = 1'b1;
                end else if (am_done) begin
                    next_state = S_FIN;
                end else begin
                    next_state = S_XFER;
                end
            end
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        case (next_state)
            S_WR_CR: begin
                instr_d = I_WR_CR;
                data_d  = ctrl_word;
            end
            S_LD_WC: begin
                instr_d = I_LD_WC;
                data_d  = wc_q;
            end
            S_LD_AD: begin
                instr_d = I_LD_AD;
                data_d  = base_q;
            end
            S_EN:    instr_d = I_EN;
            S_XFER:  valid_d = 1'b1;
            S_STEP:  step_d  = 1'b1;
            S_FIN:   fin_d   = 1'b1;
            default: instr_d = I_RD;
        endcase

        busy_d = (next_state != S_IDLE);
    end

    // Run parameters captured on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            wc_q   <= '0;
        end else if ((state == S_IDLE) && start) begin
            base_q <= base_addr;
            wc_q   <= word_cnt;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            am_instr   <= I_RD;
            am_data    <= '0;
            am_oeaddr  <= 1'b1;
            am_aci     <= 1'b1;
            am_wci     <= 1'b1;
            xfer_valid <= 1'b0;
            busy       <= 1'b0;
            fin        <= 1'b0;
            err        <= 1'b0;
            xfer_cnt   <= '0;
        end else begin
            am_instr   <= instr_d;
            am_data    <= data_d;
            am_oeaddr  <= !busy_d;
            am_aci     <= !step_d;
            am_wci     <= !step_d;
            xfer_valid <= valid_d;
            busy       <= busy_d;
            fin        <= fin_d;
            err        <= err_d;
            xfer_cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_am2940_dma_ctrl.sv
// Directed bench for am2940_dma_ctrl with a small behavioural am2940 model
// (increment mode, done when the step count reaches the loaded word count).
module tb_am2940_dma_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] base_addr;
    logic [7:0] word_cnt;
    logic [7:0] ctrl_word;
    logic [2:0] am_instr;
    logic [7:0] am_data;
    logic       am_oeaddr;
    logic       am_aci;
    logic       am_wci;
    logic [7:0] am_address;
    logic       am_done;
    logic       xfer_valid;
    logic [7:0] xfer_addr;
    logic       xfer_ready;
    logic       busy;
    logic       fin;
    logic       err;
    logic [8:0] xfer_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wc    = 8'h00;
    logic [7:0] m_steps = 8'h00;
    logic       stuck   = 1'b0;

    logic [7:0] hs_q[$];
    int         n_aci;
    int         n_wci;
    int         cyc;
    logic       got_fin;
    logic [8:0] fin_cnt;
    logic       fin_err;

    am2940_dma_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .ctrl_word  (ctrl_word),
        .am_instr   (am_instr),
        .am_data    (am_data),
        .am_oeaddr  (am_oeaddr),
        .am_aci     (am_aci),
        .am_wci     (am_wci),
        .am_address (am_address),
        .am_done    (am_done),
        .xfer_valid (xfer_valid),
        .xfer_addr  (xfer_addr),
        .xfer_ready (xfer_ready),
        .busy       (busy),
        .fin        (fin),
        .err        (err),
        .xfer_cnt   (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // am2940 model; deliberately not reset by rst_n
    always @(posedge clk) begin
        if (am_instr == 3'b101) m_addr <= am_data;
        if (am_instr == 3'b110) begin
            m_wc    <= am_data;
            m_steps <= 8'h00;
        end
        if (!am_aci) m_addr <= m_addr + 8'h01;
        if (!am_wci) m_steps <= m_steps + 8'h01;
    end

    assign am_address = m_addr;
    assign am_done    = !stuck && (m_steps == m_wc);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] cw, input logic [7:0] wc, input logic [7:0] ba);
        ctrl_word = cw;
        word_cnt  = wc;
        base_addr = ba;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, 32'(am_instr), 'h3);
        check({tag, "_data"},  32'(am_data), 0);
        check({tag, "_oe"},    32'(am_oeaddr), 1);
        check({tag, "_aci"},   32'(am_aci), 1);
        check({tag, "_wci"},   32'(am_wci), 1);
        check({tag, "_valid"}, 32'(xfer_valid), 0);
        check({tag, "_addr"},  32'(xfer_addr), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_fin"},   32'(fin), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_cnt"},   32'(xfer_cnt), 0);
    endtask

    // Sample once per cycle from the current negedge until fin shows up.
    task automatic run_until_fin(input int max_cyc);
        hs_q.delete();
        n_aci   = 0;
        n_wci   = 0;
        cyc     = 0;
        got_fin = 1'b0;
        fin_cnt = '0;
        fin_err = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (xfer_valid && xfer_ready) hs_q.push_back(xfer_addr);
            if (!am_aci) n_aci++;
            if (!am_wci) n_wci++;
            if (fin) begin
                got_fin = 1'b1;
                cyc     = i;
                fin_cnt = xfer_cnt;
                fin_err = err;
                break;
            end
            @(negedge clk);
        end
        check("fin_seen", 32'(got_fin), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = 8'h00;
        word_cnt   = 8'h00;
        ctrl_word  = 8'h00;
        xfer_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Programming sequence followed by a three-word run
        xfer_ready = 1'b1;
        do_start(8'h00, 8'h03, 8'h6C);
        check("wrcr_instr", 32'(am_instr), 'h0);
        check("wrcr_data",  32'(am_data), 'h00);
        check("wrcr_busy",  32'(busy), 1);
        check("wrcr_oe",    32'(am_oeaddr), 0);
        @(negedge clk);
        check("ldwc_instr", 32'(am_instr), 'h6);
        check("ldwc_data",  32'(am_data), 'h03);
        @(negedge clk);
        check("ldad_instr", 32'(am_instr), 'h5);
        check("ldad_data",  32'(am_data), 'h6C);
        @(negedge clk);
        check("en_instr",   32'(am_instr), 'h7);
        check("en_data",    32'(am_data), 'h00);
        check("en_valid",   32'(xfer_valid), 0);
        @(negedge clk);
        check("x1_valid",   32'(xfer_valid), 1);
        check("x1_addr",    32'(xfer_addr), 'h6C);
        check("x1_instr",   32'(am_instr), 'h3);
        run_until_fin(50);
        check("run3_cycles", 32'(cyc), 9);
        check("run3_nhs",    32'(hs_q.size()), 3);
        check("run3_a0",     32'(hs_q[0]), 'h6C);
        check("run3_a1",     32'(hs_q[1]), 'h6D);
        check("run3_a2",     32'(hs_q[2]), 'h6E);
        check("run3_aci",    32'(n_aci), 3);
        check("run3_wci",    32'(n_wci), 3);
        check("run3_cnt",    32'(fin_cnt), 3);
        check("run3_err",    32'(fin_err), 0);
        check("run3_fin_busy", 32'(busy), 1);
        @(negedge clk);
        check("run3_idle_busy", 32'(busy), 0);
        check("run3_idle_fin",  32'(fin), 0);
        check("run3_idle_oe",   32'(am_oeaddr), 1);

        // Backpressure in the first XFER
        xfer_ready = 1'b0;
        do_start(8'h00, 8'h03, 8'h6C);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", 32'(xfer_valid), 1);
            check("bp_addr",  32'(xfer_addr), 'h6C);
            check("bp_aci",   32'(am_aci), 1);
            check("bp_cnt",   32'(xfer_cnt), 0);
            if (k < 3) @(negedge clk);
        end
        xfer_ready = 1'b1;
        run_until_fin(50);
        check("bp_cycles", 32'(cyc), 9);
        check("bp_nhs",    32'(hs_q.size()), 3);
        check("bp_a0",     32'(hs_q[0]), 'h6C);
        check("bp_a2",     32'(hs_q[2]), 'h6E);
        check("bp_aci_n",  32'(n_aci), 3);
        check("bp_fcnt",   32'(fin_cnt), 3);
        check("bp_err",    32'(fin_err), 0);
        @(negedge clk);

        // Abort during LD_WC
        do_start(8'h55, 8'h03, 8'h20);
        check("ab_wrcr_data", 32'(am_data), 'h55);
        @(negedge clk);
        check("ab_ldwc_instr", 32'(am_instr), 'h6);
        abort = 1'b1;
        @(negedge clk);
        check("ab_fin",   32'(fin), 1);
        check("ab_err",   32'(err), 1);
        check("ab_instr", 32'(am_instr), 'h3);
        abort = 1'b0;
        @(negedge clk);
        check("ab_idle_busy", 32'(busy), 0);
        check("ab_idle_fin",  32'(fin), 0);
        check("ab_err_sticky", 32'(err), 1);

        // Next start clears err; abort coincident with a handshake still steps
        xfer_ready = 1'b1;
        do_start(8'h00, 8'h03, 8'h40);
        check("clr_err", 32'(err), 0);
        repeat (4) @(negedge clk);
        check("ahs_valid", 32'(xfer_valid), 1);
        check("ahs_addr",  32'(xfer_addr), 'h40);
        abort = 1'b1;
        @(negedge clk);
        check("ahs_step_aci", 32'(am_aci), 0);
        check("ahs_step_valid", 32'(xfer_valid), 0);
        check("ahs_step_cnt", 32'(xfer_cnt), 1);
        check("ahs_step_fin", 32'(fin), 0);
        abort = 1'b0;
        @(negedge clk);
        check("ahs_chk_aci", 32'(am_aci), 1);
        @(negedge clk);
        check("ahs_x2_valid", 32'(xfer_valid), 1);
        check("ahs_x2_addr",  32'(xfer_addr), 'h41);
        xfer_ready = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("axf_fin", 32'(fin), 1);
        check("axf_err", 32'(err), 1);
        check("axf_cnt", 32'(xfer_cnt), 1);
        abort = 1'b0;
        xfer_ready = 1'b1;
        @(negedge clk);

        // Runaway guard with am_done stuck low
        stuck = 1'b1;
        do_start(8'h00, 8'h00, 8'h10);
        run_until_fin(2000);
        check("rw_nhs",   32'(hs_q.size()), 256);
        check("rw_first", 32'(hs_q[0]), 'h10);
        check("rw_last",  32'(hs_q[255]), 'h0F);
        check("rw_aci",   32'(n_aci), 256);
        check("rw_cnt",   32'(fin_cnt), 256);
        check("rw_err",   32'(fin_err), 1);
        @(negedge clk);
        stuck = 1'b0;
        do_start(8'h00, 8'h01, 8'h80);
        check("rw_clr_err", 32'(err), 0);
        run_until_fin(50);
        check("one_nhs", 32'(hs_q.size()), 1);
        check("one_a0",  32'(hs_q[0]), 'h80);
        check("one_cnt", 32'(fin_cnt), 1);
        check("one_err", 32'(fin_err), 0);
        @(negedge clk);

        // Asynchronous reset in the middle of the second word
        do_start(8'h00, 8'h03, 8'h6C);
        repeat (7) @(negedge clk);
        xfer_ready = 1'b0;
        check("mr_pre_cnt",   32'(xfer_cnt), 1);
        check("mr_pre_valid", 32'(xfer_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mr");
        @(negedge clk);
        rst_n = 1'b1;
        xfer_ready = 1'b1;
        @(negedge clk);
        check("mr_post_busy",  32'(busy), 0);
        check("mr_post_instr", 32'(am_instr), 'h3);
        check("mr_post_cnt",   32'(xfer_cnt), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
